// File: rtl/router_reg_stage.sv
// rtl/router_reg_stage.sv - 1x3 router datapath register stage; optional error counter via ROUTER_REG_ERR_CNT_EN
module router_reg_stage #(
    parameter int DW  = 8,
    parameter int ECW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pkt_valid,
    input  logic [DW-1:0]  din,
    input  logic           fifo_full,
    input  logic           detect_add,
    input  logic           lfd_state,
    input  logic           ld_state,
    input  logic           laf_state,
    input  logic           full_state,
    input  logic           rst_int_reg,
    output logic [DW-1:0]  dout,
    output logic           parity_done,
    output logic           low_pkt_valid,
    output logic           err,
    output logic [ECW-1:0] err_cnt
);

    logic [DW-1:0] hold_hdr;
    logic [DW-1:0] full_byte;
    logic [DW-1:0] run_par;
    logic          parity_done_q;
    logic          new_pkt;
    logic          ld_byte;
    logic          par_rise;

    assign new_pkt  = detect_add & pkt_valid;
    // The source is stalled during full_state, so nothing on din is meaningful then.
    assign ld_byte  = ld_state & pkt_valid & ~full_state;
    assign par_rise = parity_done & ~parity_done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout          <= '0;
            hold_hdr      <= '0;
            full_byte     <= '0;
            run_par       <= '0;
            parity_done   <= 1'b0;
            parity_done_q <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
        end else begin
            // Destination 3 does not exist, so such headers never replace the held one.
            if (new_pkt && din[1:0] != 2'b11)
                hold_hdr <= din;

            if (lfd_state)
                dout <= hold_hdr;
            else if (ld_byte && !fifo_full)
                dout <= din;
            else if (ld_byte && fifo_full)
                full_byte <= din;
            else if (laf_state)
                dout <= full_byte;

            if (detect_add)
                run_par <= '0;
            else if (lfd_state)
                run_par <= hold_hdr;
            else if (ld_byte)
                run_par <= run_par ^ din;

            parity_done_q <= parity_done;
            if (new_pkt)
                parity_done <= 1'b0;
            else if ((ld_state && !pkt_valid && !fifo_full) ||
                     (laf_state && low_pkt_valid && !parity_done))
                parity_done <= 1'b1;

            if (ld_state && !pkt_valid)
                low_pkt_valid <= 1'b1;
            else if (rst_int_reg)
                low_pkt_valid <= 1'b0;

            if (new_pkt)
                err <= 1'b0;
            else if (par_rise)
                err <= |run_par;
        end
    end

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [ECW-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            err_cnt_q <= '0;
        else if (!new_pkt && par_rise && (|run_par) && err_cnt_q != {ECW{1'b1}})
            err_cnt_q <= err_cnt_q + ECW'(1);
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
